mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 32, byte-address width.
- STARVE_MAX, 3, maximum consecutive data grants while fetch waits.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on posedge.
- rst, in, 1, synchronous active-high reset.
- if_req, in, 1, fetch request; held until if_gnt.
- if_addr, in, ADDR_W, fetch address; word access.
- if_gnt, out, 1, fetch accepted this cycle.
- if_rvalid, out, 1, one-cycle pulse: if_rdata valid.
- if_rdata, out, 32, fetched instruction.
- d_req, in, 1, data request; held until d_gnt.
- d_we, in, 1, 1 = store, 0 = load.
- d_func3, in, 3, RV32I load/store funct3.
- d_addr, in, ADDR_W, data byte address.
- d_wdata, in, 32, store data.
- d_gnt, out, 1, data request accepted this cycle.
- d_rvalid, out, 1, one-cycle pulse: load data or store completion.
- d_rdata, out, 32, load result; 0 for stores and errors.
- d_err, out, 1, qualifies d_rvalid: misaligned access or illegal funct3.
- mem_addr, out, ADDR_W, shared port address.
- mem_func3, out, 3, shared port access size.
- mem_wdata, out, 32, shared port write data.
- mem_read, out, 1, shared port read strobe.
- mem_write, out, 1, shared port write strobe; memory commits on the negedge of the same cycle.
- mem_rdata, in, 32, shared port read data, valid the cycle after issue.

Function
REQ-003 FSM states SHALL be IDLE, IF_WAIT, D_WAIT and ERR_RSP; at most one access SHALL be in flight.
REQ-004 Grants SHALL be issued only in IDLE and are combinational in the request cycle; mem_* SHALL be driven in that same cycle.
REQ-005 Arbitration in IDLE SHALL grant data over fetch, except when starve_cnt == STARVE_MAX and if_req is high, in which case fetch SHALL win.
REQ-006 starve_cnt SHALL increment on each data grant while if_req is high, clear on a fetch grant or whenever if_req is low, and saturate at STARVE_MAX.
REQ-007 A fetch grant SHALL drive mem_read=1, mem_func3=3'b010 and mem_addr=if_addr, then transition to IF_WAIT.
REQ-008 In IF_WAIT the block SHALL pulse if_rvalid, set if_rdata=mem_rdata, and return to IDLE.
REQ-009 A legal data grant SHALL drive mem_read=~d_we, mem_write=d_we, mem_func3=d_func3, mem_addr=d_addr and mem_wdata=d_wdata, then transition to D_WAIT.
REQ-010 In D_WAIT the block SHALL pulse d_rvalid with d_err=0, set d_rdata=mem_rdata for loads and 0 for stores, and return to IDLE.
REQ-011 Legal accesses SHALL be:
- loads with func3 in {0,1,2,4,5};
- stores with func3 in {0,1,2};
- halfword at an even address;
- word with addr[1:0]==0.
REQ-012 Any other data request SHALL still receive d_gnt, SHALL assert no mem strobe, and SHALL go to ERR_RSP.
REQ-013 ERR_RSP SHALL pulse d_rvalid and d_err with d_rdata=0, then return to IDLE.
REQ-014 A fetch with if_addr[1:0]!=0 SHALL be issued unchanged; alignment of fetches is the requester's responsibility.
REQ-015 mem_read and mem_write SHALL never be high together, and SHALL be 0 outside the grant cycle.
REQ-016 Sustained throughput SHALL be one access per two cycles; request-to-rvalid latency SHALL be 1 cycle after the grant cycle.
REQ-017 When requests arrive simultaneously, the loser's request SHALL stay pending without reissue and SHALL be arbitrated again at the next IDLE.

Reset
REQ-018 With rst high at posedge, state SHALL go to IDLE, starve_cnt to 0, and all registered outputs (rvalids, rdatas, d_err) to 0.
REQ-019 Grants and mem strobes SHALL be forced to 0 while rst is high.
REQ-020 An access in flight when rst asserts SHALL be dropped with no rvalid; a store issued in the reset-assert cycle SHALL not occur, because strobes are gated.

Structure
REQ-021 Package mem_arb_pkg SHALL hold the state enum, the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the default STARVE_MAX.
REQ-022 One combinational sub-module, mem_align_check, SHALL compute legality from d_we, d_func3 and d_addr[1:0].

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Fetch only, if_addr=0x10, mem_rdata=0x00500093: if_gnt in cycle 0, if_rvalid with if_rdata=0x00500093 in cycle 1.
- d_req with if_req in the same cycle, d_addr=0x20, lw: d_gnt first, if_gnt at the next IDLE (cycle 2).
- d_req and if_req held continuously: grant order D,D,D,IF,D,D,D,IF; starve_cnt never exceeds 3.
- sh at 0x21, and lw at 0x22: d_gnt, no mem_write or mem_read, d_rvalid and d_err=1 next cycle, d_rdata=0.
- sb 0xAB at 0x30: mem_write=1 with func3=0 in the grant cycle; d_rvalid with d_rdata=0 next cycle.
- rst asserted in D_WAIT of a load: no d_rvalid, state IDLE, all outputs 0 in the following cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IF_WAIT,
    D_WAIT,
    ERR_RSP
  } arb_state_e;

  // RV32I load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  // RV32I store funct3 encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int unsigned STARVE_MAX_DEFAULT = 3;

endpackage

// File: rtl/mem_align_check.sv
// Decides whether a data access has a legal funct3 for its direction and is
// naturally aligned for its size.
module mem_align_check
  import mem_arb_pkg::*;
(
  input  logic       we_i,
  input  logic [2:0] func3_i,
  input  logic [1:0] addr_lo_i,
  output logic       legal_o
);

  always_comb begin
    legal_o = 1'b0;
    if (we_i) begin
      case (func3_i)
        SB:      legal_o = 1'b1;
        SH:      legal_o = ~addr_lo_i[0];
        SW:      legal_o = (addr_lo_i == 2'b00);
        default: legal_o = 1'b0;
      endcase
    end else begin
      case (func3_i)
        LB, LBU: legal_o = 1'b1;
        LH, LHU: legal_o = ~addr_lo_i[0];
        LW:      legal_o = (addr_lo_i == 2'b00);
        default: legal_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-cycle memory port between instruction fetch and data
// accesses; data has priority, with a bounded starvation counter for fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_func3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_func3,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic            d_load_q;
  logic            d_legal;

  mem_align_check u_align (
    .we_i      (d_we),
    .func3_i   (d_func3),
    .addr_lo_i (d_addr[1:0]),
    .legal_o   (d_legal)
  );

  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_addr  = '0;
    mem_func3 = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    state_d   = state_q;
    starve_d  = if_req ? starve_q : '0;
    case (state_q)
      IDLE: begin
        if (!rst) begin
          if (if_req && (!d_req || starve_q == StarveMax)) begin
            if_gnt    = 1'b1;
            mem_read  = 1'b1;
            mem_func3 = LW;
            mem_addr  = if_addr;
            starve_d  = '0;
            state_d   = IF_WAIT;
          end else if (d_req) begin
            d_gnt = 1'b1;
            if (if_req && starve_q != StarveMax) begin
              starve_d = starve_q + 1'b1;
            end
            // Illegal accesses are granted but never reach the memory.
            if (d_legal) begin
              mem_read  = ~d_we;
              mem_write = d_we;
              mem_func3 = d_func3;
              mem_addr  = d_addr;
              mem_wdata = d_wdata;
              state_d   = D_WAIT;
            end else begin
              state_d = ERR_RSP;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Responses are decoded from state so they line up with mem_rdata.
  always_comb begin
    if_rvalid = (state_q == IF_WAIT) && !rst;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rvalid  = ((state_q == D_WAIT) || (state_q == ERR_RSP)) && !rst;
    d_err     = (state_q == ERR_RSP) && !rst;
    d_rdata   = ((state_q == D_WAIT) && !rst && d_load_q) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      d_load_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (d_gnt) begin
        d_load_q <= ~d_we;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a request-level reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW   = 32;
  localparam int          SMAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [2:0]    d_func3;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata, d_rdata;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_func3;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_read, mem_write;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_func3(mem_func3), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Legal when funct3 is valid for the direction and addr is a multiple of the size.
  function automatic bit legal_ref(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit ok;
    int sz;
    if (we) ok = (f3 <= 3'd2);
    else    ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz = 1 << int'(f3 % 3'd4);
    return ok && ((a % sz) == 0);
  endfunction

  typedef enum {RNone, RIf, RLoad, RStore, RErr} rsp_e;

  rsp_e  rsp;
  bit    if_pend, d_pend, g_if, g_d, lg;
  int    starve;
  string pat;
  logic [31:0] rd;

  initial begin
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h4; d_req = 1'b1; d_we = 1'b1;
    d_func3 = SW; d_addr = 32'h8; d_wdata = 32'h55; mem_rdata = 32'h0;
    @(negedge clk); #1;
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("idle_if_rvalid", if_rvalid, 0);
    chk("idle_d_rvalid", d_rvalid, 0);

    // Fetch only
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10; #1;
    chk("f_if_gnt", if_gnt, 1);
    chk("f_mem_read", mem_read, 1);
    chk("f_mem_func3", mem_func3, LW);
    chk("f_mem_addr", mem_addr, 32'h10);
    @(negedge clk);
    if_req = 1'b0; mem_rdata = 32'h0050_0093; #1;
    chk("f_if_rvalid", if_rvalid, 1);
    chk("f_if_rdata", if_rdata, 32'h0050_0093);
    chk("f_if_gnt_wait", if_gnt, 0);

    // Simultaneous data and fetch: data first, fetch at the next IDLE
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_func3 = LW;
    d_addr = 32'h20; #1;
    chk("sim_d_gnt", d_gnt, 1);
    chk("sim_if_gnt0", if_gnt, 0);
    chk("sim_mem_addr", mem_addr, 32'h20);
    @(negedge clk);
    d_req = 1'b0; mem_rdata = 32'hCAFE_F00D; #1;
    chk("sim_d_rvalid", d_rvalid, 1);
    chk("sim_d_rdata", d_rdata, 32'hCAFE_F00D);
    chk("sim_if_gnt1", if_gnt, 0);
    @(negedge clk); #1;
    chk("sim_if_gnt2", if_gnt, 1);
    chk("sim_mem_addr2", mem_addr, 32'h100);
    @(negedge clk);
    if_req = 1'b0; #1;
    chk("sim_if_rvalid", if_rvalid, 1);

    // Both held: starvation bound forces a fetch every fourth grant
    @(negedge clk);
    pat = "DDDIDDDI";
    if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_func3 = LW; d_addr = 32'h40;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("starve_d_gnt%0d", k), d_gnt, (pat[k] == "D"));
      chk($sformatf("starve_if_gnt%0d", k), if_gnt, (pat[k] == "I"));
      @(negedge clk); #1;
      chk($sformatf("starve_busy%0d", k), if_gnt | d_gnt, 0);
      @(negedge clk);
    end
    if_req = 1'b0; d_req = 1'b0;

    // Misaligned sh and lw
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      d_req = 1'b1; d_we = (k == 0); d_func3 = (k == 0) ? SH : LW;
      d_addr = (k == 0) ? 32'h21 : 32'h22; #1;
      chk($sformatf("mis%0d_d_gnt", k), d_gnt, 1);
      chk($sformatf("mis%0d_strobes", k), {mem_read, mem_write}, 0);
      @(negedge clk);
      d_req = 1'b0; mem_rdata = 32'h1111_2222; #1;
      chk($sformatf("mis%0d_d_rvalid", k), d_rvalid, 1);
      chk($sformatf("mis%0d_d_err", k), d_err, 1);
      chk($sformatf("mis%0d_d_rdata", k), d_rdata, 0);
    end

    // sb 0xAB at 0x30
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_func3 = SB; d_addr = 32'h30; d_wdata = 32'hAB; #1;
    chk("sb_d_gnt", d_gnt, 1);
    chk("sb_mem_write", mem_write, 1);
    chk("sb_mem_read", mem_read, 0);
    chk("sb_mem_func3", mem_func3, SB);
    chk("sb_mem_addr", mem_addr, 32'h30);
    chk("sb_mem_wdata", mem_wdata, 32'hAB);
    @(negedge clk);
    d_req = 1'b0; mem_rdata = 32'h7777_7777; #1;
    chk("sb_d_rvalid", d_rvalid, 1);
    chk("sb_d_err", d_err, 0);
    chk("sb_d_rdata", d_rdata, 0);

    // Reset during D_WAIT of a load
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_func3 = LW; d_addr = 32'h44; #1;
    chk("rl_d_gnt", d_gnt, 1);
    @(negedge clk);
    d_req = 1'b0; rst = 1'b1; mem_rdata = 32'h1234_5678; #1;
    chk("rl_d_rvalid_in_rst", d_rvalid, 0);
    chk("rl_d_rdata_in_rst", d_rdata, 0);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("rl_after_valids", {if_rvalid, d_rvalid, d_err}, 0);
    chk("rl_after_d_rdata", d_rdata, 0);
    chk("rl_after_if_rdata", if_rdata, 0);
    chk("rl_after_gnts", {if_gnt, d_gnt, mem_read, mem_write}, 0);

    // Randomized traffic against the request-level model
    rsp = RNone; if_pend = 0; d_pend = 0; starve = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!if_pend && ($urandom_range(0, 3) != 0)) begin
        if_pend = 1; if_addr = $urandom;
      end
      if (!d_pend && ($urandom_range(0, 3) != 0)) begin
        d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_func3 = 3'($urandom_range(0, 7));
        d_addr = $urandom; d_wdata = $urandom;
      end
      if_req = if_pend; d_req = d_pend; mem_rdata = $urandom; rd = mem_rdata;
      #1;
      chk("r_if_rvalid", if_rvalid, (rsp == RIf));
      chk("r_d_rvalid", d_rvalid, (rsp inside {RLoad, RStore, RErr}));
      chk("r_d_err", d_err, (rsp == RErr));
      if (rsp == RIf) chk("r_if_rdata", if_rdata, rd);
      if (rsp inside {RLoad, RStore, RErr}) chk("r_d_rdata", d_rdata, (rsp == RLoad) ? rd : 0);
      g_if = 0; g_d = 0;
      if (rsp == RNone) begin
        g_if = if_pend && (!d_pend || starve == SMAX);
        g_d  = d_pend && !g_if;
      end
      rsp = RNone;
      chk("r_if_gnt", if_gnt, g_if);
      chk("r_d_gnt", d_gnt, g_d);
      lg = g_d && legal_ref(d_we, d_func3, d_addr);
      chk("r_mem_read", mem_read, g_if || (lg && !d_we));
      chk("r_mem_write", mem_write, lg && d_we);
      if (g_if) begin
        chk("r_if_mem_addr", mem_addr, if_addr);
        chk("r_if_mem_func3", mem_func3, LW);
        rsp = RIf; if_pend = 0;
      end
      if (g_d) begin
        if (lg) begin
          chk("r_d_mem_addr", mem_addr, d_addr);
          chk("r_d_mem_func3", mem_func3, d_func3);
          chk("r_d_mem_wdata", mem_wdata, d_wdata);
          rsp = d_we ? RStore : RLoad;
        end else begin
          rsp = RErr;
        end
        d_pend = 0;
      end
      if (!if_req || g_if) starve = 0;
      else if (g_d) starve = (starve < SMAX) ? starve + 1 : SMAX;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
